// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types and helpers for the shared data-memory arbiter.
// Optional feature macro: MEM_ARB_FIXED_PRIO_EN (fixed lowest-index priority instead of round-robin).
package shared_mem_arbiter_pkg;

    localparam int unsigned DEF_NUM_CORES   = 4;
    localparam int unsigned DEF_MEM_LATENCY = 2;
    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_rr_priority_picker.sv
// Combinational winner picker: first requester at or after ptr_i (round-robin),
// or lowest-index requester when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_priority_picker
    import shared_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned IDX_W     = idx_width(DEF_NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
`ifndef MEM_ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0]     ptr_i,
`endif
    output logic                 valid_o,
    output logic [NUM_CORES-1:0] onehot_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            cand = IDX_W'(k);
`else
            cand = IDX_W'((32'(ptr_i) + k) % NUM_CORES);
`endif
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
        onehot_o = valid_o ? (NUM_CORES'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbitrates a single-port data memory between NUM_CORES cores, one access in flight.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no round-robin pointer).
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES   = DEF_NUM_CORES,
    parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic [NUM_CORES-1:0]        core_stall,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int unsigned IDX_W = idx_width(NUM_CORES);
    localparam int unsigned CNT_W = idx_width(MEM_LATENCY + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CORES-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

    logic                 pick_valid;
    logic [NUM_CORES-1:0] pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    rr_priority_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i    (req),
`ifndef MEM_ARB_FIXED_PRIO_EN
        .ptr_i    (rr_ptr_q),
`endif
        .valid_o  (pick_valid),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    // One-hot AND-OR mux of the winning core's request fields.
    always_comb begin
        sel_we    = |(we & pick_onehot);
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (pick_onehot[k]) begin
                sel_addr  = sel_addr  | addr[k*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Request fields are latched here, so later input changes are ignored.
                if (pick_valid) begin
                    grant_d     = pick_idx;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    ack_d   = NUM_CORES'(1) << grant_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                rr_ptr_d = (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + IDX_W'(1);
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_stall = req & ~ack_q;

endmodule
